// File: rtl/crc8_frame_checker.sv
// CRC-8 frame checker for 10-byte frames.
// Payload bytes 1..7 are CRC-covered; byte 8 carries the CRC.
module crc8_frame_checker #(
  parameter logic [7:0] POLYNOMIAL = 8'h07,
  parameter logic [7:0] INITIAL    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  input  logic        sof_i,
  output logic [7:0]  payload_o,
  output logic        payload_valid_o,
  output logic        frame_done_o,
  output logic        crc_ok_o,
  output logic        crc_err_o,
  output logic        abort_o,
  output logic [7:0]  rx_crc_o,
  output logic [7:0]  calc_crc_o,
  output logic [15:0] err_count_o,
  output logic [3:0]  byte_counter
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC,
    TRAILER
  } state_t;

  state_t      state, state_n;
  logic [7:0]  crc_q, crc_n;
  logic [3:0]  cnt_n;
  logic [7:0]  payload_n;
  logic        pvalid_n;
  logic        done_n;
  logic        ok_n;
  logic        err_n;
  logic        abort_n;
  logic [7:0]  rx_n;
  logic [7:0]  calc_n;
  logic [15:0] errcnt_n;

  // MSB-first byte update, no reflection.
  function automatic logic [7:0] crc_fold(
    input logic [7:0] crc,
    input logic [7:0] d
  );
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ POLYNOMIAL;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Next-state, CRC datapath and pulse decode.
  always_comb begin
    state_n   = state;
    cnt_n     = byte_counter;
    crc_n     = crc_q;
    payload_n = payload_o;
    pvalid_n  = 1'b0;
    done_n    = 1'b0;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    abort_n   = 1'b0;
    rx_n      = rx_crc_o;
    calc_n    = calc_crc_o;
    errcnt_n  = err_count_o;
    if (data_valid_i) begin
      if (sof_i) begin
        // A new header always restarts; mid-frame it aborts.
        abort_n = (state != IDLE);
        state_n = PAYLOAD;
        cnt_n   = 4'd1;
        crc_n   = INITIAL;
      end else begin
        unique case (state)
          IDLE: begin
            state_n = IDLE;
          end
          PAYLOAD: begin
            crc_n     = crc_fold(crc_q, data_i);
            payload_n = data_i;
            pvalid_n  = 1'b1;
            cnt_n     = byte_counter + 4'd1;
            if (byte_counter == 4'd7) state_n = CRC;
          end
          CRC: begin
            rx_n    = data_i;
            calc_n  = crc_q;
            cnt_n   = 4'd9;
            state_n = TRAILER;
          end
          TRAILER: begin
            done_n  = 1'b1;
            ok_n    = (rx_crc_o == calc_crc_o);
            err_n   = (rx_crc_o != calc_crc_o);
            cnt_n   = 4'd0;
            state_n = IDLE;
          end
        endcase
      end
    end
    if ((err_n || abort_n) && err_count_o != 16'hFFFF)
      errcnt_n = err_count_o + 16'd1;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      byte_counter    <= 4'd0;
      crc_q           <= INITIAL;
      payload_o       <= 8'h00;
      payload_valid_o <= 1'b0;
      frame_done_o    <= 1'b0;
      crc_ok_o        <= 1'b0;
      crc_err_o       <= 1'b0;
      abort_o         <= 1'b0;
      rx_crc_o        <= 8'h00;
      calc_crc_o      <= 8'h00;
      err_count_o     <= 16'h0000;
    end else begin
      state           <= state_n;
      byte_counter    <= cnt_n;
      crc_q           <= crc_n;
      payload_o       <= payload_n;
      payload_valid_o <= pvalid_n;
      frame_done_o    <= done_n;
      crc_ok_o        <= ok_n;
      crc_err_o       <= err_n;
      abort_o         <= abort_n;
      rx_crc_o        <= rx_n;
      calc_crc_o      <= calc_n;
      err_count_o     <= errcnt_n;
    end
  end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Scoreboard bench for crc8_frame_checker.
// Payload and frame results are queued at drive time, popped on output.
module tb_crc8_frame_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        sof_i;
  logic [7:0]  payload_o;
  logic        payload_valid_o;
  logic        frame_done_o;
  logic        crc_ok_o;
  logic        crc_err_o;
  logic        abort_o;
  logic [7:0]  rx_crc_o;
  logic [7:0]  calc_crc_o;
  logic [15:0] err_count_o;
  logic [3:0]  byte_counter;

  crc8_frame_checker dut (
    .clk             (clk),
    .reset           (reset),
    .data_i          (data_i),
    .data_valid_i    (data_valid_i),
    .sof_i           (sof_i),
    .payload_o       (payload_o),
    .payload_valid_o (payload_valid_o),
    .frame_done_o    (frame_done_o),
    .crc_ok_o        (crc_ok_o),
    .crc_err_o       (crc_err_o),
    .abort_o         (abort_o),
    .rx_crc_o        (rx_crc_o),
    .calc_crc_o      (calc_crc_o),
    .err_count_o     (err_count_o),
    .byte_counter    (byte_counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ok;
    logic [7:0] rx;
    logic [7:0] calc;
  } frame_exp_t;

  logic [7:0] pay_q[$];
  frame_exp_t frm_q[$];
  frame_exp_t fe;
  logic [7:0] pe;

  int n_pass  = 0;
  int n_total = 0;
  int n_abort = 0;
  int n_done  = 0;

  bit          mid;
  int          exp_abort;
  logic [15:0] exp_err;
  logic [7:0]  crc_m;
  logic [7:0]  rx_m;
  logic [7:0]  calc_m;
  logic [3:0]  idx;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bit-serial reference: feedback = msb xor next data bit.
  function automatic logic [7:0] ref_fold(input logic [7:0] c,
                                          input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Monitor: pop scoreboard entries as the DUT pulses.
  always @(negedge clk) begin
    if (payload_valid_o) begin
      if (pay_q.size() == 0) begin
        check("payload_unexpected", payload_valid_o, 0);
      end else begin
        pe = pay_q.pop_front();
        check("payload_o", payload_o, pe);
      end
    end
    if (frame_done_o) begin
      n_done++;
      if (frm_q.size() == 0) begin
        check("frame_unexpected", frame_done_o, 0);
      end else begin
        fe = frm_q.pop_front();
        check("crc_ok_o", crc_ok_o, fe.ok);
        check("crc_err_o", crc_err_o, !fe.ok);
        check("rx_crc_o", rx_crc_o, fe.rx);
        check("calc_crc_o", calc_crc_o, fe.calc);
      end
    end
    if (frame_done_o || crc_ok_o || crc_err_o)
      check("done_ok_xor_err", {frame_done_o, crc_ok_o ^ crc_err_o}, 2'b11);
    if (abort_o) n_abort++;
  end

  task automatic drive(input logic [7:0] d, input logic s);
    data_i       = d;
    sof_i        = s;
    data_valid_i = 1'b1;
    @(negedge clk);
    data_valid_i = 1'b0;
    sof_i        = 1'b0;
  endtask

  task automatic b_sof(input logic [7:0] d);
    if (mid) begin
      exp_abort++;
      exp_err = sat_inc(exp_err);
    end
    mid   = 1'b1;
    crc_m = 8'hFF;
    idx   = 4'd1;
    drive(d, 1'b1);
  endtask

  task automatic b_pay(input logic [7:0] d);
    pay_q.push_back(d);
    crc_m = ref_fold(crc_m, d);
    idx   = idx + 4'd1;
    drive(d, 1'b0);
  endtask

  task automatic b_crc(input logic [7:0] d);
    rx_m   = d;
    calc_m = crc_m;
    idx    = 4'd9;
    drive(d, 1'b0);
  endtask

  task automatic b_trl(input logic [7:0] d);
    frame_exp_t f;
    f.ok   = (rx_m == calc_m);
    f.rx   = rx_m;
    f.calc = calc_m;
    frm_q.push_back(f);
    if (!f.ok) exp_err = sat_inc(exp_err);
    mid = 1'b0;
    idx = 4'd0;
    drive(d, 1'b0);
  endtask

  task automatic stall(input int n);
    data_valid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_i = 8'hEE;
      sof_i  = i[0];
      @(negedge clk);
      check("stall_pulses",
            {payload_valid_o, frame_done_o, crc_ok_o, crc_err_o, abort_o},
            5'b0);
      check("stall_byte_counter", byte_counter, idx);
    end
    sof_i = 1'b0;
  endtask

  task automatic full_frame(input logic [7:0] p, input logic [7:0] c,
                            input int stall_after);
    b_sof(8'hA5);
    for (int i = 1; i <= 7; i++) begin
      b_pay(p + i[7:0] * 8'(p != 8'h00));
      if (i == stall_after) stall(3);
    end
    b_crc(c);
    b_trl(8'h5A);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    data_valid_i = 1'b1;
    sof_i        = 1'b0;
    data_i       = 8'h00;
    @(negedge clk);
    reset        = 1'b0;
    data_valid_i = 1'b0;
    mid          = 1'b0;
    idx          = 4'd0;
    exp_err      = 16'h0;
  endtask

  task automatic settle();
    data_valid_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int a0, d0;

  initial begin
    exp_abort = 0;
    do_reset();
    do_reset();
    check("rst_outputs",
          {payload_valid_o, frame_done_o, crc_ok_o, crc_err_o, abort_o},
          5'b0);
    check("rst_regs", {payload_o, rx_crc_o, calc_crc_o}, 24'h0);
    check("rst_err_count", err_count_o, 16'h0);
    check("rst_byte_counter", byte_counter, 4'd0);

    // Bytes without sof in IDLE are dropped.
    drive(8'h33, 1'b0);
    drive(8'h44, 1'b0);
    settle();
    check("idle_drop_counter", byte_counter, 4'd0);

    // Good frame, zero payload, CRC 0x44.
    d0 = n_done;
    full_frame(8'h00, 8'h44, 0);
    settle();
    check("good_done", n_done - d0, 1);
    check("good_rx", rx_crc_o, 8'h44);
    check("good_calc", calc_crc_o, 8'h44);
    check("good_err", err_count_o, exp_err);
    check("good_counter", byte_counter, 4'd0);

    // Bad CRC byte.
    full_frame(8'h00, 8'h45, 0);
    settle();
    check("bad_rx", rx_crc_o, 8'h45);
    check("bad_calc", calc_crc_o, 8'h44);
    check("bad_err", err_count_o, 16'd1);

    // Good frame with a 3-cycle stall after byte 4.
    do_reset();
    full_frame(8'h00, 8'h44, 4);
    settle();
    check("stall_calc", calc_crc_o, 8'h44);
    check("stall_err", err_count_o, 16'd0);

    // Non-zero payload, CRC from the reference.
    crc_m = 8'hFF;
    for (int i = 1; i <= 7; i++) crc_m = ref_fold(crc_m, 8'h10 + i[7:0]);
    full_frame(8'h10, crc_m, 0);
    settle();
    check("var_err", err_count_o, exp_err);

    // sof at byte 6, then a good frame.
    do_reset();
    a0 = n_abort;
    d0 = n_done;
    b_sof(8'hA5);
    for (int i = 1; i <= 5; i++) b_pay(8'h00);
    full_frame(8'h00, 8'h44, 0);
    settle();
    check("abort6_count", n_abort - a0, 1);
    check("abort6_done", n_done - d0, 1);
    check("abort6_err", err_count_o, 16'd1);

    // sof together with the trailer byte.
    a0 = n_abort;
    d0 = n_done;
    b_sof(8'hA5);
    for (int i = 1; i <= 7; i++) b_pay(8'h00);
    b_crc(8'h45);
    full_frame(8'h00, 8'h44, 0);
    settle();
    check("abort_trl_count", n_abort - a0, 1);
    check("abort_trl_done", n_done - d0, 1);
    check("abort_trl_err", err_count_o, exp_err);

    // Reset mid-frame after byte 3.
    do_reset();
    a0 = n_abort;
    b_sof(8'hA5);
    for (int i = 1; i <= 3; i++) b_pay(8'h00);
    do_reset();
    check("midrst_counter", byte_counter, 4'd0);
    full_frame(8'h00, 8'h44, 0);
    settle();
    check("midrst_abort", n_abort - a0, 0);
    check("midrst_err", err_count_o, 16'd0);

    // Saturation: repeated sof aborts, then bad frames.
    do_reset();
    for (int i = 0; i < 65534; i++) b_sof(8'h11);
    settle();
    check("sat_pre", err_count_o, 16'hFFFD);
    for (int k = 0; k < 3; k++) begin
      full_frame(8'h00, 8'h45, 0);
      settle();
      check("sat_err", err_count_o, exp_err);
    end
    check("sat_final", err_count_o, 16'hFFFF);

    check("abort_total", n_abort, exp_abort);
    check("pay_q_drained", pay_q.size(), 0);
    check("frm_q_drained", frm_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
